// File: rtl/axi4_sram_slave_if.sv
// AXI4 bus bundle between a master and the SRAM slave.
// The slave modport is the memory end; the master modport drives requests.
interface axi4_sram_slave_if #(
    parameter int ID_W = 4
);
    logic            arvalid, arready;
    logic [31:0]     araddr;
    logic [ID_W-1:0] arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;

    logic            rvalid, rready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic [ID_W-1:0] rid;

    logic            awvalid, awready;
    logic [31:0]     awaddr;
    logic [ID_W-1:0] awid;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;

    logic            wvalid, wready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;

    logic            bvalid, bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 slave in front of a single-port word SRAM, one transaction at a time, reads first.
// Optional AXI_SLV_RAND_DELAY_EN inserts LFSR-driven stall cycles on every channel.
module axi4_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          READ_LAT    = 1,
    parameter int          ID_W        = 4
) (
    input  logic             clock,
    input  logic             reset,
    axi4_sram_slave_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_DATA, WR_RESP} state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            fixed_q, fixed_d;
    logic            cfg_err_q, cfg_err_d;
    logic [15:0]     lat_q, lat_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      resp_q, resp_d;
    logic            rlast_q, rlast_d;

    logic [31:0]     mem [DEPTH_WORDS];
    logic            mem_we, load_beat, in_range, wl_err;
    logic [29:0]     woff;
    logic [AW-1:0]   idx;
    logic [1:0]      beat_resp;
    logic            gap, addr_gate;
    logic            ar_hs, aw_hs, r_hs, w_hs, b_hs;

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Unsigned subtract: addresses below BASE_ADDR wrap high and fail the range check too.
    assign woff      = 30'((addr_q - BASE_ADDR) >> 2);
    assign in_range  = (addr_q >= BASE_ADDR) && ({2'b00, woff} < 32'(DEPTH_WORDS));
    assign idx       = woff[AW-1:0];
    assign beat_resp = cfg_err_q ? 2'b10 : (!in_range ? 2'b11 : 2'b00);
    assign wl_err    = bus.wlast != (cnt_q == 8'd0);

    assign bus.arready = reset && (state_q == IDLE) && addr_gate;
    assign bus.awready = reset && (state_q == IDLE) && addr_gate && !bus.arvalid;
    assign bus.rvalid  = (state_q == RD_BEAT) && !gap;
    assign bus.wready  = (state_q == WR_DATA) && !gap;
    assign bus.bvalid  = (state_q == WR_RESP) && !gap;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = resp_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = id_q;
    assign bus.bresp   = resp_q;
    assign bus.bid     = id_q;

    assign ar_hs = bus.arvalid && bus.arready;
    assign aw_hs = bus.awvalid && bus.awready;
    assign r_hs  = bus.rvalid && bus.rready;
    assign w_hs  = bus.wvalid && bus.wready;
    assign b_hs  = bus.bvalid && bus.bready;

`ifdef AXI_SLV_RAND_DELAY_EN
    logic [7:0] lfsr_q;
    logic [1:0] dly_q;
    logic       load_dly;

    assign load_dly  = (state_d != state_q) || r_hs || w_hs;
    assign gap       = (dly_q != 2'd0);
    assign addr_gate = ~lfsr_q[2];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 8'hA5;
            dly_q  <= 2'd0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (load_dly)  dly_q <= lfsr_q[1:0];
            else if (gap)  dly_q <= dly_q - 2'd1;
        end
    end
`else
    assign gap       = 1'b0;
    assign addr_gate = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        fixed_d   = fixed_q;
        cfg_err_d = cfg_err_q;
        lat_d     = lat_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        rlast_d   = rlast_q;
        mem_we    = 1'b0;
        load_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    state_d   = RD_WAIT;
                    addr_d    = bus.araddr;
                    cnt_d     = bus.arlen;
                    id_d      = bus.arid;
                    fixed_d   = (bus.arburst == 2'b00);
                    cfg_err_d = bus.arburst[1] || (bus.arsize != 3'b010);
                    lat_d     = 16'(READ_LAT - 1);
                end else if (aw_hs) begin
                    state_d   = WR_DATA;
                    addr_d    = bus.awaddr;
                    cnt_d     = bus.awlen;
                    id_d      = bus.awid;
                    fixed_d   = (bus.awburst == 2'b00);
                    cfg_err_d = bus.awburst[1] || (bus.awsize != 3'b010);
                    resp_d    = 2'b00;
                end
            end
            RD_WAIT: begin
                if (lat_q == 16'd0) begin
                    load_beat = 1'b1;
                    state_d   = RD_BEAT;
                end else begin
                    lat_d = lat_q - 16'd1;
                end
            end
            RD_BEAT: begin
                if (r_hs) begin
                    if (rlast_q) state_d   = IDLE;
                    else         load_beat = 1'b1;
                end
            end
            WR_DATA: begin
                if (w_hs) begin
                    mem_we = (beat_resp == 2'b00);
                    resp_d = worst(worst(resp_q, beat_resp), wl_err ? 2'b10 : 2'b00);
                    addr_d = fixed_q ? addr_q : addr_q + 32'd4;
                    if (cnt_q == 8'd0) state_d = WR_RESP;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            end
            WR_RESP: begin
                if (b_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A beat is fetched into the output register one cycle before it is presented.
        if (load_beat) begin
            rdata_d = (beat_resp == 2'b00) ? mem[idx] : 32'd0;
            resp_d  = beat_resp;
            rlast_d = (cnt_q == 8'd0);
            cnt_d   = cnt_q - 8'd1;
            addr_d  = fixed_q ? addr_q : addr_q + 32'd4;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            id_q      <= '0;
            fixed_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            lat_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            rlast_q   <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            fixed_q   <= fixed_d;
            cfg_err_q <= cfg_err_d;
            lat_q     <= lat_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            rlast_q   <= rlast_d;
        end
    end

    // SRAM contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: stimulus pushes expected R/B responses,
// a monitor pops and compares them as the slave presents them.
module tb_axi4_sram_slave;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    axi4_sram_slave_if #(.ID_W(4)) bus ();

    axi4_sram_slave #(
        .BASE_ADDR(32'h3000_0000), .DEPTH_WORDS(4096), .READ_LAT(1), .ID_W(4)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;
    typedef struct packed {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    rbeat_t exp_r[$];
    bexp_t  exp_b[$];
    int     total = 0, bad = 0, rlast_cnt = 0;
    logic   rr_toggle = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic exp_rd(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
        exp_r.push_back({d, r, l, id});
    endtask

    // Monitor: compare every R/B handshake and check held R outputs across stalls.
    initial begin : monitor
        logic        stall;
        logic [39:0] held;
        rbeat_t      e;
        bexp_t       eb;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                stall = 1'b0;
            end else begin
                if (stall)
                    chk("r_hold", {bus.rvalid, bus.rdata, bus.rresp, bus.rlast, bus.rid}, held);
                stall = bus.rvalid && !bus.rready;
                held  = {bus.rvalid, bus.rdata, bus.rresp, bus.rlast, bus.rid};
                if (bus.rvalid && bus.rready) begin
                    if (exp_r.size() == 0) begin
                        total++; bad++;
                        $display("FAIL r_unexpected: got beat %h, required none", bus.rdata);
                    end else begin
                        e = exp_r.pop_front();
                        chk("r_beat", {bus.rdata, bus.rresp, bus.rlast, bus.rid}, e);
                        if (bus.rlast) rlast_cnt++;
                    end
                end
                if (bus.bvalid && bus.bready) begin
                    if (exp_b.size() == 0) begin
                        total++; bad++;
                        $display("FAIL b_unexpected: got bresp %h, required none", bus.bresp);
                    end else begin
                        eb = exp_b.pop_front();
                        chk("b_resp", {bus.bresp, bus.bid}, eb);
                    end
                end
            end
        end
    end

    initial begin : rready_drv
        bus.rready = 1'b1;
        forever begin
            @(posedge clock); #1;
            bus.rready = rr_toggle ? ~bus.rready : 1'b1;
        end
    end

    task automatic ar_send(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                           input logic [1:0] burst, input logic [2:0] size);
        int n;
        @(posedge clock); #1;
        bus.araddr = a; bus.arlen = len; bus.arid = id; bus.arburst = burst; bus.arsize = size;
        bus.arvalid = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (!bus.arready && n < 200);
        if (!bus.arready) timeout("ar_handshake");
        @(posedge clock); #1 bus.arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                           input logic [1:0] burst, input logic [2:0] size);
        int n;
        @(posedge clock); #1;
        bus.awaddr = a; bus.awlen = len; bus.awid = id; bus.awburst = burst; bus.awsize = size;
        bus.awvalid = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (!bus.awready && n < 200);
        if (!bus.awready) timeout("aw_handshake");
        @(posedge clock); #1 bus.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] strb, input logic last);
        int n;
        @(posedge clock); #1;
        bus.wdata = d; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (!bus.wready && n < 200);
        if (!bus.wready) timeout("w_handshake");
        @(posedge clock); #1 bus.wvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 500) begin
            @(negedge clock); n++;
        end
        if (exp_r.size() != 0 || exp_b.size() != 0) begin
            timeout("drain");
            exp_r.delete();
            exp_b.delete();
        end
        @(negedge clock);
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [3:0] id, input logic [1:0] burst,
                             input logic [2:0] size, input logic [3:0] strb,
                             input logic [31:0] d [4], input int nb,
                             input logic [1:0] eresp, input bit early);
        exp_b.push_back({eresp, id});
        aw_send(a, 8'(nb - 1), id, burst, size);
        for (int i = 0; i < nb; i++) w_send(d[i], strb, early || (i == nb - 1));
        wait_drain();
    endtask

    task automatic read_txn(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                            input logic [1:0] burst, input logic [2:0] size);
        ar_send(a, len, id, burst, size);
        wait_drain();
    endtask

    initial begin : stim
        int n, rc;
        bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        bus.bready = 1'b1;

        #3;
        chk("rst_ctrl", {bus.arready, bus.awready, bus.rvalid, bus.wready, bus.bvalid, bus.rlast}, 6'd0);
        chk("rst_data", {bus.rdata, bus.rresp, bus.rid, bus.bresp, bus.bid}, 44'd0);
        @(negedge clock) reset = 1'b1;

        // Preload through the bus
        write_txn(32'h3000_0000, 4'd1, 2'b01, 3'b010, 4'hF, '{32'h0010_0093, 0, 0, 0}, 1, 2'b00, 0);
        write_txn(32'h3000_0010, 4'd2, 2'b01, 3'b010, 4'hF,
                  '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003}, 4, 2'b00, 0);

        // Single read with latency check
        exp_rd(32'h0010_0093, 2'b00, 1'b1, 4'd3);
        ar_send(32'h3000_0000, 8'd0, 4'd3, 2'b01, 3'b010);
        @(negedge clock); chk("lat_edge_n", bus.rvalid, 1'b0);
        @(negedge clock); chk("lat_edge_n1", bus.rvalid, 1'b1);
        wait_drain();

        // INCR burst with rready toggling
        rr_toggle = 1'b1;
        exp_rd(32'hA000_0000, 2'b00, 1'b0, 4'd4);
        exp_rd(32'hA000_0001, 2'b00, 1'b0, 4'd4);
        exp_rd(32'hA000_0002, 2'b00, 1'b0, 4'd4);
        exp_rd(32'hA000_0003, 2'b00, 1'b1, 4'd4);
        read_txn(32'h3000_0010, 8'd3, 4'd4, 2'b01, 3'b010);
        rr_toggle = 1'b0;

        // Byte-masked write
        write_txn(32'h3000_0020, 4'd5, 2'b01, 3'b010, 4'hF, '{32'h1111_1111, 0, 0, 0}, 1, 2'b00, 0);
        write_txn(32'h3000_0020, 4'd5, 2'b01, 3'b010, 4'b0011, '{32'hDEAD_BEEF, 0, 0, 0}, 1, 2'b00, 0);
        exp_rd(32'h1111_BEEF, 2'b00, 1'b1, 4'd5);
        read_txn(32'h3000_0020, 8'd0, 4'd5, 2'b01, 3'b010);
        write_txn(32'h3000_0020, 4'd5, 2'b01, 3'b010, 4'b0000, '{32'h0BAD_0BAD, 0, 0, 0}, 1, 2'b00, 0);
        exp_rd(32'h1111_BEEF, 2'b00, 1'b1, 4'd5);
        read_txn(32'h3000_0020, 8'd0, 4'd5, 2'b01, 3'b010);

        // Decode errors
        exp_rd(32'd0, 2'b11, 1'b1, 4'd6);
        read_txn(32'h2FFF_FFFC, 8'd0, 4'd6, 2'b01, 3'b010);
        write_txn(32'h3000_3FFC, 4'd7, 2'b01, 3'b010, 4'hF, '{32'hCAFE_F00D, 0, 0, 0}, 1, 2'b00, 0);
        exp_rd(32'hCAFE_F00D, 2'b00, 1'b0, 4'd7);
        exp_rd(32'd0, 2'b11, 1'b1, 4'd7);
        read_txn(32'h3000_3FFC, 8'd1, 4'd7, 2'b01, 3'b010);
        write_txn(32'h3000_0000, 4'd9, 2'b01, 3'b001, 4'hF, '{32'hFFFF_FFFF, 0, 0, 0}, 1, 2'b10, 0);
        write_txn(32'h4000_0000, 4'd8, 2'b01, 3'b010, 4'hF, '{32'h1234_5678, 0, 0, 0}, 1, 2'b11, 0);
        exp_rd(32'h0010_0093, 2'b00, 1'b1, 4'd8);
        read_txn(32'h3000_0000, 8'd0, 4'd8, 2'b01, 3'b010);

        // WRAP burst -> SLVERR on every beat
        exp_rd(32'd0, 2'b10, 1'b0, 4'd14);
        exp_rd(32'd0, 2'b10, 1'b1, 4'd14);
        read_txn(32'h3000_0010, 8'd1, 4'd14, 2'b10, 3'b010);

        // FIXED write then FIXED read
        write_txn(32'h3000_0040, 4'd2, 2'b00, 3'b010, 4'hF, '{32'd1, 32'd2, 32'd3, 0}, 3, 2'b00, 0);
        exp_rd(32'd3, 2'b00, 1'b0, 4'd2);
        exp_rd(32'd3, 2'b00, 1'b1, 4'd2);
        read_txn(32'h3000_0040, 8'd1, 4'd2, 2'b00, 3'b010);

        // Early wlast: SLVERR, data still written
        write_txn(32'h3000_0050, 4'd6, 2'b01, 3'b010, 4'hF, '{32'h5050_5050, 32'h5454_5454, 0, 0}, 2, 2'b10, 1);
        exp_rd(32'h5050_5050, 2'b00, 1'b0, 4'd1);
        exp_rd(32'h5454_5454, 2'b00, 1'b1, 4'd1);
        read_txn(32'h3000_0050, 8'd1, 4'd1, 2'b01, 3'b010);

        // Contention: read wins, write waits for rlast
        exp_rd(32'hA000_0000, 2'b00, 1'b1, 4'd10);
        exp_b.push_back({2'b00, 4'd11});
        @(posedge clock); #1;
        bus.araddr = 32'h3000_0010; bus.arlen = 0; bus.arid = 4'd10; bus.arburst = 2'b01; bus.arsize = 3'b010;
        bus.awaddr = 32'h3000_0060; bus.awlen = 0; bus.awid = 4'd11; bus.awburst = 2'b01; bus.awsize = 3'b010;
        bus.arvalid = 1'b1; bus.awvalid = 1'b1;
        @(negedge clock);
        chk("ctn_ready", {bus.arready, bus.awready}, 2'b10);
        rc = rlast_cnt;
        @(posedge clock); #1 bus.arvalid = 1'b0;
        n = 0;
        do begin @(negedge clock); n++; end while (!bus.awready && n < 200);
        if (!bus.awready) timeout("ctn_aw");
        chk("ctn_order", 64'(rlast_cnt), 64'(rc + 1));
        @(posedge clock); #1 bus.awvalid = 1'b0;
        w_send(32'h5555_AAAA, 4'hF, 1'b1);
        wait_drain();
        exp_rd(32'h5555_AAAA, 2'b00, 1'b1, 4'd11);
        read_txn(32'h3000_0060, 8'd0, 4'd11, 2'b01, 3'b010);

        // Async reset in the middle of a write burst
        write_txn(32'h3000_0070, 4'd3, 2'b01, 3'b010, 4'hF, '{32'h7070_7070, 32'h7474_7474, 0, 0}, 2, 2'b00, 0);
        aw_send(32'h3000_0070, 8'd1, 4'd12, 2'b01, 3'b010);
        w_send(32'h7777_0000, 4'hF, 1'b0);
        @(negedge clock);
        chk("rst_pre_wready", bus.wready, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_ctrl", {bus.arready, bus.awready, bus.rvalid, bus.wready, bus.bvalid, bus.rlast}, 6'd0);
        chk("rst_mid_data", {bus.rdata, bus.rresp, bus.rid, bus.bresp, bus.bid}, 44'd0);
        @(negedge clock) reset = 1'b1;
        exp_rd(32'h7777_0000, 2'b00, 1'b0, 4'd13);
        exp_rd(32'h7474_7474, 2'b00, 1'b1, 4'd13);
        read_txn(32'h3000_0070, 8'd1, 4'd13, 2'b01, 3'b010);

        chk("queues_empty", 64'(exp_r.size() + exp_b.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end
endmodule
